// File: rtl/lc_clk_byp_resp.sv
// Responder side of the life-cycle clock-bypass handshake: synchronizes the
// multibit request, steers the clock muxes and returns a multibit acknowledge.
module lc_clk_byp_resp #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   localparam int unsigned CNT_W         = $clog2(TIMEOUT_CYCLES)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] lc_clk_byp_req_i,
   input  logic       clk_byp_done_i,
   output logic       byp_sel_o,
   output logic [3:0] lc_clk_byp_ack_o,
   output logic       fatal_err_o
);

   localparam logic [3:0] LC_ON  = 4'b1010;
   localparam logic [3:0] LC_OFF = 4'b0101;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SWITCH  = 3'd1;
   localparam logic [2:0] ST_ACK     = 3'd2;
   localparam logic [2:0] ST_RELEASE = 3'd3;
   localparam logic [2:0] ST_ERROR   = 3'd4;

   logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
   logic [3:0]                  req_s;
   logic                        req_on_q, req_on_d;
   logic                        req_inv_q, req_inv_d;
   logic                        req_inv_prev_q, req_inv_prev_d;
   logic [2:0]                  state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [CNT_W-1:0]            cnt_inc;
   logic                        timeout;

   assign req_s = sync_q[SYNC_STAGES-1];

   // Decode is registered so the FSM never sees the synchronizer output directly.
   always_comb begin
      sync_d         = {sync_q[SYNC_STAGES-2:0], lc_clk_byp_req_i};
      req_on_d       = (req_s == LC_ON);
      req_inv_d      = (req_s != LC_ON) && (req_s != LC_OFF);
      req_inv_prev_d = req_inv_q;
   end

   assign cnt_inc = cnt_q + 1'b1;
   assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_on_q) state_d = ST_SWITCH;
         end
         ST_SWITCH: begin
            if (clk_byp_done_i)  state_d = ST_ACK;
            else if (!req_on_q)  state_d = ST_RELEASE;
            else if (timeout)    state_d = ST_ERROR;
            else                 cnt_d   = cnt_inc;
         end
         ST_ACK: begin
            if (!req_on_q)            state_d = ST_RELEASE;
            else if (!clk_byp_done_i) state_d = ST_ERROR;
         end
         ST_RELEASE: begin
            if (!clk_byp_done_i) state_d = ST_IDLE;
            else if (timeout)    state_d = ST_ERROR;
            else                 cnt_d   = cnt_inc;
         end
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_ERROR;
      endcase
      // A persistent invalid encoding overrides whatever the FSM wanted.
      if (req_inv_q && req_inv_prev_q) state_d = ST_ERROR;
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q         <= {SYNC_STAGES{LC_OFF}};
         req_on_q       <= 1'b0;
         req_inv_q      <= 1'b0;
         req_inv_prev_q <= 1'b0;
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
      end else begin
         sync_q         <= sync_d;
         req_on_q       <= req_on_d;
         req_inv_q      <= req_inv_d;
         req_inv_prev_q <= req_inv_prev_d;
         state_q        <= state_d;
         cnt_q          <= cnt_d;
      end
   end

   assign byp_sel_o        = (state_q == ST_SWITCH) || (state_q == ST_ACK);
   assign lc_clk_byp_ack_o = (state_q == ST_ACK) ? LC_ON : LC_OFF;
   assign fatal_err_o      = (state_q == ST_ERROR);

endmodule
